ones_pattern_gen: RTL and testbench

- Inverse of the team's population-count block. Given a target count k, emits every 16-bit vector with exactly k ones, in strictly increasing numeric order, one vector per valid/ready handshake.
- Feeds exhaustive stimulus into count_ones checkers. Every emitted vector is also an input whose expected popcount is known.
- Single clock domain; sits between the test controller (start/k) and a downstream consumer (valid/ready).

---
 rtl/ones_gen_pkg.sv | 34 +++
 rtl/ones_pattern_gen_if.sv | 32 +++
 rtl/ones_pattern_gen_tz_count.sv | 21 ++
 rtl/ones_pattern_gen.sv | 123 ++++++++++++
 tb/tb_ones_pattern_gen.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ones_gen_pkg.sv
// rtl/ones_gen_pkg.sv - shared widths, state encoding and helper functions for ones_pattern_gen
//   W  : vector width
//   CW : width of the ones count k (clog2(W+1))
//   IW : width of the sequence index (2^IW > C(W, W/2))
package ones_gen_pkg;

  localparam int W  = 16;
  localparam int CW = 5;
  localparam int IW = 14;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  // Low n bits set; n == W gives all ones.
  function automatic logic [W-1:0] ones_mask(input logic [CW-1:0] n);
    logic [W-1:0] m;
    for (int i = 0; i < W; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

  function automatic int count_ones(input logic [W-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < W; i++) begin
      c += int'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/ones_pattern_gen_if.sv
// rtl/ones_pattern_gen_if.sv - output stream bundle of ones_pattern_gen
//   out_valid : out_vec/out_index/out_last are valid (master -> slave)
//   out_ready : consumer accepts the current pattern (slave -> master)
//   out_vec   : current W-bit pattern
//   out_index : zero-based position of out_vec in the run
//   out_last  : out_vec is the final pattern of the run
interface ones_pattern_gen_if
  import ones_gen_pkg::*;
;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_vec;
  logic [IW-1:0] out_index;
  logic          out_last;

  modport master (
    output out_valid,
    output out_vec,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_vec,
    input  out_index,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/ones_pattern_gen_tz_count.sv
// rtl/ones_pattern_gen_tz_count.sv - combinational trailing-zero counter
//   vec : W-bit input
//   tz  : number of trailing zeros of vec; W when vec is zero
module tz_count
  import ones_gen_pkg::*;
(
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] tz
);

  // Scan from the MSB down so the lowest set bit is the last to win.
  always_comb begin
    tz = CW'(W);
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        tz = CW'(i);
      end
    end
  end

endmodule

// File: rtl/ones_pattern_gen.sv
// rtl/ones_pattern_gen.sv - emits every W-bit vector with exactly k ones in increasing order
//   clk, rst_n : clock, asynchronous active-low reset
//   start, k   : begin a run with k ones (sampled in IDLE only)
//   busy       : high from the accepted start until the final handshake
//   done       : one-cycle pulse after the final handshake
//   err        : one-cycle pulse when start arrives with k > W
//   out_if     : valid/ready output stream (vector, index, last)
module ones_pattern_gen
  import ones_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CW-1:0]     k,
  output logic              busy,
  output logic              done,
  output logic              err,
  ones_pattern_gen_if.master out_if
);

  state_t        state_q, state_d;
  logic [W-1:0]  vec_q, vec_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] k_q, k_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [CW-1:0] tz;
  logic [W:0]    v_ext;
  logic [W:0]    lsb;
  logic [W:0]    sum;
  logic [W:0]    nxt;
  logic [CW:0]   shamt;
  logic          nxt_carry_unused;
  logic [W-1:0]  last_pat;
  logic          last;
  logic          xfer;

  tz_count u_tz (
    .vec (vec_q),
    .tz  (tz)
  );

  // Next pattern with equal popcount: add the lowest set bit to ripple the
  // lowest run of ones upward, then refill the freed ones at the bottom.
  // One extra bit keeps the sum from wrapping; the final pattern never
  // advances, so that bit is always zero when nxt is used.
  assign v_ext            = {1'b0, vec_q};
  assign lsb              = v_ext & (~v_ext + (W+1)'(1));
  assign sum              = v_ext + lsb;
  assign shamt            = {1'b0, tz} + (CW+1)'(2);
  assign nxt              = sum | ((sum ^ v_ext) >> shamt);
  assign nxt_carry_unused = nxt[W];

  // Largest pattern with k_q ones: all ones packed at the top.
  assign last_pat = ones_mask(k_q) << (CW'(W) - k_q);
  assign last     = (vec_q == last_pat);

  assign xfer = out_if.out_valid && out_if.out_ready;

  assign out_if.out_valid = (state_q == EMIT);
  assign out_if.out_vec   = vec_q;
  assign out_if.out_index = idx_q;
  assign out_if.out_last  = (state_q == EMIT) && last;
  assign busy             = (state_q == EMIT);
  assign done             = done_q;
  assign err              = err_q;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    idx_d   = idx_q;
    k_d     = k_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (k > CW'(W)) begin
            err_d = 1'b1;
          end else begin
            state_d = EMIT;
            k_d     = k;
            vec_d   = ones_mask(k);
            idx_d   = '0;
          end
        end
      end
      EMIT: begin
        // start is deliberately ignored here; the running k stays intact.
        if (xfer) begin
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            vec_d = nxt[W-1:0];
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      idx_q   <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ones_pattern_gen.sv
// tb/tb_ones_pattern_gen.sv - self-checking bench for ones_pattern_gen
module tb_ones_pattern_gen;
  import ones_gen_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] k = '0;
  logic          busy;
  logic          done;
  logic          err;

  ones_pattern_gen_if bus ();

  ones_pattern_gen dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .k      (k),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .out_if (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  vec;
    logic [IW-1:0] idx;
    logic          last;
  } exp_t;

  typedef struct {
    logic [CW-1:0] kk;
    bit            rnd;
    int            total;
    logic [W-1:0]  first;
    logic [W-1:0]  lastv;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[5];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference sequence by brute-force enumeration; called at posedge+1 in IDLE.
  task automatic launch(input logic [CW-1:0] kk);
    int   n;
    exp_t e;
    n = 0;
    sb.delete();
    for (int v = 0; v < (1 << W); v++) begin
      if (count_ones(W'(v)) == int'(kk)) begin
        e.vec  = W'(v);
        e.idx  = IW'(n);
        e.last = 1'b0;
        sb.push_back(e);
        n++;
      end
    end
    if (n > 0) sb[n-1].last = 1'b1;
    start = 1'b1;
    k     = kk;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_valid", bus.out_valid, 1);
    check("start_busy", busy, 1);
  endtask

  task automatic consume(input bit rnd, input int max_x, input logic [CW-1:0] kk, input bit full,
                         input int total, input logic [W-1:0] first, input logic [W-1:0] lastv);
    int            n;
    int            cyc;
    bit            seen_last;
    bit            have_prev;
    bit            held;
    logic [W-1:0]  prev, hv, first_v, last_v;
    logic [IW-1:0] hi, last_i;
    logic          hl;
    exp_t          e;
    n = 0; cyc = 0; seen_last = 0; have_prev = 0; held = 0;
    prev = '0; hv = '0; hi = '0; hl = 0; first_v = '0; last_v = '0; last_i = '0;
    while (!seen_last && n < max_x && cyc < 40000) begin
      bus.out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(negedge clk);
      if (held) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_vec", bus.out_vec, hv);
        check("hold_index", bus.out_index, hi);
        check("hold_last", bus.out_last, hl);
      end
      held = 0;
      check("run_busy", busy, 1);
      check("run_done_low", done, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check("vec", bus.out_vec, e.vec);
          check("index", bus.out_index, e.idx);
          check("last", bus.out_last, e.last);
        end
        check("popcount", count_ones(bus.out_vec), int'(kk));
        if (have_prev) check("ascending", bus.out_vec > prev, 1);
        if (n == 0) first_v = bus.out_vec;
        prev      = bus.out_vec;
        have_prev = 1;
        last_v    = bus.out_vec;
        last_i    = bus.out_index;
        seen_last = bus.out_last;
        n++;
      end else if (bus.out_valid) begin
        held = 1;
        hv   = bus.out_vec;
        hi   = bus.out_index;
        hl   = bus.out_last;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (full) begin
      check("run_completed", seen_last, 1);
      check("count", n, total);
      check("first_vec", first_v, first);
      check("final_vec", last_v, lastv);
      check("final_index", last_i, total - 1);
      check("sb_empty", sb.size(), 0);
      check("done_pulse", done, 1);
      check("busy_after", busy, 0);
      check("valid_after", bus.out_valid, 0);
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      check("done_clear", done, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.out_ready = 1'b0;
    tbl[0] = '{5'd1,  1'b0, 16,    16'h0001, 16'h8000};
    tbl[1] = '{5'd2,  1'b0, 120,   16'h0003, 16'hC000};
    tbl[2] = '{5'd0,  1'b0, 1,     16'h0000, 16'h0000};
    tbl[3] = '{5'd16, 1'b0, 1,     16'hFFFF, 16'hFFFF};
    tbl[4] = '{5'd8,  1'b1, 12870, 16'h00FF, 16'hFF00};

    #2;
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_vec", bus.out_vec, 0);
    check("rst_index", bus.out_index, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // k > W is rejected with a single err pulse.
    start = 1'b1;
    k     = 5'd17;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_pulse", err, 1);
    check("err_valid", bus.out_valid, 0);
    check("err_busy", busy, 0);
    @(posedge clk); #1;
    check("err_clear", err, 0);
    check("err_valid2", bus.out_valid, 0);

    for (int i = 0; i < 5; i++) begin
      launch(tbl[i].kk);
      consume(tbl[i].rnd, 100000, tbl[i].kk, 1'b1, tbl[i].total, tbl[i].first, tbl[i].lastv);
    end

    // Backpressure at the first vector, with a stray start in the middle.
    launch(5'd3);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        start = 1'b1;
        k     = 5'd5;
      end
      @(negedge clk);
      check("bp_valid", bus.out_valid, 1);
      check("bp_vec", bus.out_vec, 16'h0007);
      check("bp_index", bus.out_index, 0);
      @(posedge clk); #1;
      start = 1'b0;
    end
    consume(1'b0, 100000, 5'd3, 1'b1, 560, 16'h0007, 16'hE000);

    // Asynchronous reset in the middle of a k=8 run, then a fresh run.
    launch(5'd8);
    consume(1'b0, 100, 5'd8, 1'b0, 0, 16'h0000, 16'h0000);
    bus.out_ready = 1'b0;
    #2;
    check("pre_rst_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_vec", bus.out_vec, 0);
    check("mid_rst_index", bus.out_index, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    launch(5'd8);
    check("restart_vec", bus.out_vec, 16'h00FF);
    check("restart_index", bus.out_index, 0);
    consume(1'b0, 3, 5'd8, 1'b0, 0, 16'h0000, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
